// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder sequencer: FSM state
// encoding and the legal WIDTH range with its check function.
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;

  function automatic bit widthLegal(input int unsigned w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full adder built from two gate-level half-adder stages whose
// carries are merged by an OR gate. Purely combinational.
module serial_fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);

  logic halfSum;
  logic halfCarry1;
  logic halfCarry2;

  xor uHa1Sum   (halfSum, a_i, b_i);
  and uHa1Carry (halfCarry1, a_i, b_i);
  xor uHa2Sum   (s_o, halfSum, c_i);
  and uHa2Carry (halfCarry2, halfSum, c_i);
  or  uCarryOr  (co_o, halfCarry1, halfCarry2);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: accepts two WIDTH-bit operands, feeds them
// LSB-first through a single full-adder cell one bit per clock, then
// presents sum and carry-out over a valid/ready handshake.
// Optional feature: define SERIAL_ADD_OVF_EN to add the signed-overflow
// output ovf.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam bit          WidthOk = widthLegal(WIDTH);
  localparam int unsigned CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] aSh_q, aSh_d;
  logic [WIDTH-1:0] bSh_q, bSh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic faSum;
  logic faCarry;

  // Flag an elaboration with a WIDTH outside the supported range.
  widthCheck: assert property (@(posedge clk) WidthOk);

  serial_fa_cell uFa (
    .a_i  (aSh_q[0]),
    .b_i  (bSh_q[0]),
    .c_i  (carry_q),
    .s_o  (faSum),
    .co_o (faCarry)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Datapath registers: operand shifters, carry, bit counter and results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aSh_q   <= '0;
      bSh_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      aSh_q   <= aSh_d;
      bSh_q   <= bSh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Next-state and datapath update: load on accept, one bit per RUN cycle,
  // hold everything in DONE until the consumer takes the result.
  always_comb begin
    state_d = state_q;
    aSh_d   = aSh_q;
    bSh_d   = bSh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          aSh_d   = a;
          bSh_d   = b;
          carry_d = 1'b0;
          cnt_d   = '0;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        aSh_d   = {1'b0, aSh_q[WIDTH-1:1]};
        bSh_d   = {1'b0, bSh_q[WIDTH-1:1]};
        sum_d   = {faSum, sum_q[WIDTH-1:1]};
        carry_d = faCarry;
        if (cnt_q == CntLast) begin
          cout_d  = faCarry;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = carry_q ^ faCarry;
`endif
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE) & ~rst;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN) | (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
